// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC generator, one-cycle imem request path and a
// DEPTH-entry {pc, inst} prefetch FIFO. Define FETCHQ_BYPASS_EN for the empty-FIFO bypass.
module fetch_queue #(
  parameter int unsigned     XLEN     = 64,
  parameter int unsigned     ILEN     = 32,
  parameter int unsigned     ADDR_W   = 16,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_en,
  output logic                       im_req,
  output logic [ADDR_W-1:0]          im_addr,
  input  logic [ILEN-1:0]            im_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       d_valid,
  input  logic                       d_ready,
  output logic [XLEN-1:0]            d_pc,
  output logic [ILEN-1:0]            d_inst,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH+1);

`ifdef FETCHQ_BYPASS_EN
  localparam bit BypassEn = 1'b1;
`else
  localparam bit BypassEn = 1'b0;
`endif

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            inflight_q, inflight_d;
  logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic [ILEN-1:0] inst_mem_q [DEPTH];

  logic            resp_valid;
  logic            fifo_empty;
  logic            bypass_sel;
  logic            pop;
  logic            fifo_pop;
  logic            push;
  logic [CntW:0]   pending;
  logic            unused_rpc;

  assign unused_rpc = ^redirect_pc[1:0];

  always_comb begin
    resp_valid = inflight_q & ~kill_q;
    fifo_empty = (count_q == '0);
    bypass_sel = BypassEn & fifo_empty & resp_valid;
    d_valid    = rst & ~redirect_valid & (~fifo_empty | bypass_sel);
    pop        = d_valid & d_ready;
    fifo_pop   = pop & ~fifo_empty;
    // A bypassed response accepted in the same cycle never touches the FIFO.
    push       = resp_valid & ~redirect_valid & ~(bypass_sel & d_ready);
    pending    = {1'b0, count_q} + (CntW+1)'(inflight_q) - (CntW+1)'(pop);
    im_req     = rst & fetch_en & ~redirect_valid & (pending < (CntW+1)'(DEPTH));
    im_addr    = fetch_pc_q[ADDR_W-1:0];
    d_pc       = bypass_sel ? inflight_pc_q : pc_mem_q[rd_ptr_q];
    d_inst     = bypass_sel ? im_rdata : inst_mem_q[rd_ptr_q];
    occupancy  = count_q;
  end

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    inflight_d    = im_req;
    inflight_pc_d = im_req ? fetch_pc_q : inflight_pc_q;
    kill_d        = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      kill_d     = inflight_q;
    end else begin
      if (im_req)   fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (push)     wr_ptr_d   = wr_ptr_q + PtrW'(1);
      if (fifo_pop) rd_ptr_d   = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(fifo_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q    <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      kill_q        <= 1'b0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      kill_q        <= kill_d;
    end
  end

  // Storage is cleared on reset so the head outputs read zero while in reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]   <= '0;
        inst_mem_q[i] <= '0;
      end
    end else if (push) begin
      pc_mem_q[wr_ptr_q]   <= inflight_pc_q;
      inst_mem_q[wr_ptr_q] <= im_rdata;
    end
  end

  push_not_full: assert property (@(posedge clk) disable iff (!rst)
    !(push && (count_q == CntW'(DEPTH))));

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue (default build): cycle table plus an
// in-order scoreboard of expected decode PCs, and reset/throughput sequences.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        im_req;
  logic [15:0] im_addr;
  logic [31:0] im_rdata;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        d_valid;
  logic        d_ready;
  logic [63:0] d_pc;
  logic [31:0] d_inst;
  logic [2:0]  occupancy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [63:0] sb_q[$];

  fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_rdata       (im_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .d_valid        (d_valid),
    .d_ready        (d_ready),
    .d_pc           (d_pc),
    .d_inst         (d_inst),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [63:0] pc);
    return {~pc[15:0], pc[15:0]};
  endfunction

  // Instruction memory: data valid exactly one cycle after the request.
  always @(posedge clk) im_rdata <= im_req ? inst_of(64'(im_addr)) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_reload(input logic [63:0] base);
    sb_q.delete();
    for (int k = 0; k < 32; k++) sb_q.push_back(base + 64'(4 * k));
  endtask

  // Scoreboard: every accepted decode entry must be the next expected PC.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (rst && d_valid && d_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_empty: got pc %h want nothing at %0t", d_pc, $time);
        end else begin
          exp = sb_q.pop_front();
          chk("sb_pc", d_pc, exp);
          chk("sb_inst", 64'(d_inst), 64'(inst_of(exp)));
        end
      end
    end
  end

  typedef struct {
    logic        fe;
    logic        rdy;
    logic        rv;
    logic [63:0] rpc;
    logic        req;
    logic [15:0] addr;
    logic        dv;
    logic [63:0] pc;
    logic [2:0]  occ;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int first_req;
    int first_dv;
    int pops;

    //         fe    rdy   rv    rpc         req   addr      dv    pc          occ
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 64'h0,     1'b1, 16'h0000, 1'b0, 64'h0,     3'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 64'h0,     1'b1, 16'h0004, 1'b0, 64'h0,     3'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 64'h0,     1'b1, 16'h0008, 1'b1, 64'h0,     3'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 64'h0,     1'b1, 16'h000C, 1'b1, 64'h0,     3'd2};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 64'h0,     1'b0, 16'h0010, 1'b1, 64'h0,     3'd3};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 64'h0,     1'b0, 16'h0010, 1'b1, 64'h0,     3'd4};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h0010, 1'b1, 64'h0,     3'd4};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h0014, 1'b1, 64'h4,     3'd3};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h0018, 1'b1, 64'h8,     3'd3};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 64'h1002,  1'b0, 16'h001C, 1'b0, 64'h0,     3'd3};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h1000, 1'b0, 64'h0,     3'd0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h1004, 1'b0, 64'h0,     3'd0};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h1008, 1'b1, 64'h1000,  3'd1};
    tbl[13] = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h100C, 1'b1, 64'h1004,  3'd1};
    tbl[14] = '{1'b1, 1'b1, 1'b1, 64'h200,   1'b0, 16'h1010, 1'b0, 64'h0,     3'd1};
    tbl[15] = '{1'b1, 1'b1, 1'b1, 64'h300,   1'b0, 16'h0200, 1'b0, 64'h0,     3'd0};
    tbl[16] = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h0300, 1'b0, 64'h0,     3'd0};
    tbl[17] = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h0304, 1'b0, 64'h0,     3'd0};
    tbl[18] = '{1'b1, 1'b1, 1'b0, 64'h0,     1'b1, 16'h0308, 1'b1, 64'h300,   3'd1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 64'h0,     1'b0, 16'h030C, 1'b1, 64'h304,   3'd1};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 64'h0,     1'b0, 16'h030C, 1'b1, 64'h304,   3'd2};
    tbl[21] = '{1'b0, 1'b0, 1'b0, 64'h0,     1'b0, 16'h030C, 1'b1, 64'h304,   3'd2};

    rst            = 1'b0;
    fetch_en       = 1'b1;
    d_ready        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    sb_reload(64'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 64'(im_req), 64'h0);
    chk("rst_dv", 64'(d_valid), 64'h0);
    chk("rst_occ", 64'(occupancy), 64'h0);
    chk("rst_pc", d_pc, 64'h0);
    rst = 1'b1;

    // Backpressure, redirect with in-flight request, double redirect, fetch_en low.
    for (int i = 0; i < 22; i++) begin
      fetch_en       = tbl[i].fe;
      d_ready        = tbl[i].rdy;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      if (tbl[i].rv) sb_reload({tbl[i].rpc[63:2], 2'b00});
      @(negedge clk);
      chk($sformatf("v%0d_req", i), 64'(im_req), 64'(tbl[i].req));
      chk($sformatf("v%0d_addr", i), 64'(im_addr), 64'(tbl[i].addr));
      chk($sformatf("v%0d_dv", i), 64'(d_valid), 64'(tbl[i].dv));
      chk($sformatf("v%0d_occ", i), 64'(occupancy), 64'(tbl[i].occ));
      if (tbl[i].dv) begin
        chk($sformatf("v%0d_pc", i), d_pc, tbl[i].pc);
        chk($sformatf("v%0d_inst", i), 64'(d_inst), 64'(inst_of(tbl[i].pc)));
      end
      @(posedge clk);
      #1;
    end

    // Fill the FIFO, then reset asynchronously mid-cycle.
    fetch_en = 1'b1;
    d_ready  = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    chk("full_occ", 64'(occupancy), 64'd4);
    chk("full_req", 64'(im_req), 64'h0);
    chk("full_head", d_pc, 64'h304);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_req", 64'(im_req), 64'h0);
    chk("arst_dv", 64'(d_valid), 64'h0);
    chk("arst_occ", 64'(occupancy), 64'h0);
    chk("arst_pc", d_pc, 64'h0);
    chk("arst_inst", 64'(d_inst), 64'h0);
    d_ready = 1'b1;
    sb_reload(64'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rel_req", 64'(im_req), 64'h1);
    chk("rel_addr", 64'(im_addr), 64'h0);

    // Streaming with d_ready high: latency 2 and one entry per cycle.
    first_req = -1;
    first_dv  = -1;
    pops      = 0;
    for (int k = 0; k < 20; k++) begin
      if (im_req && first_req < 0) first_req = k;
      if (d_valid && first_dv < 0) first_dv = k;
      if (d_valid) pops++;
      @(negedge clk);
      #1;
    end
    chk("first_req", 64'(first_req), 64'd0);
    chk("first_dv", 64'(first_dv), 64'd2);
    chk("stream_pops", 64'(pops), 64'd18);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
